fft_sym_packer: RTL and testbench

- Sits directly downstream of the CP-removal stage on the receive path, ahead of the FFT.
- Accepts the CP-removed AXIS stream (no backpressure upstream) and stores whole OFDM symbols in a store-and-forward FIFO.
- Releases only complete, correctly sized symbols to the FFT over a backpressured AXIS master.
- Discards malformed or overflowed symbols whole and reports them in status.

---
 rtl/fft_sym_packer.sv | 227 ++++++++++++++++++++++
 tb/tb_fft_sym_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sym_packer.sv
// Store-and-forward packer between CP removal and the FFT: buffers whole symbols,
// forwards only complete FFT_BEATS-long ones, drops the rest and reports why.
module fft_sym_packer #(
   parameter int unsigned DATA_W         = 128,
   parameter int unsigned FFT_BEATS      = 256,
   parameter int unsigned FIFO_DEPTH     = 512,
   parameter int unsigned SYMS_PER_FRAME = 14
) (
   input  logic                          s_axis_aclk,
   input  logic                          s_axis_aresetn,
   input  logic [DATA_W-1:0]             s_cp_rm_axis_tdata,
   input  logic                          s_cp_rm_axis_tvalid,
   input  logic [7:0]                    s_cp_rm_axis_tid,
   input  logic                          s_cp_rm_axis_tlast,
   output logic [DATA_W-1:0]             m_fft_axis_tdata,
   output logic                          m_fft_axis_tvalid,
   input  logic                          m_fft_axis_tready,
   output logic [7:0]                    m_fft_axis_tid,
   output logic [7:0]                    m_fft_axis_tuser,
   output logic                          m_fft_axis_tlast,
   input  logic                          clr_status,
   output logic                          overflow,
   output logic                          len_err,
   output logic [15:0]                   dropped_syms,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned BW = $clog2(FFT_BEATS);
   localparam int unsigned MW = DATA_W + 8;

   typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} wr_state_e;

   wr_state_e         state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     cm_ptr_q, cm_ptr_d;
   logic [PW-1:0]     cm_rd_q, cm_rd_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [BW-1:0]     wr_beat_q, wr_beat_d;
   logic [BW-1:0]     rd_beat_q, rd_beat_d;
   logic [7:0]        sym_q, sym_d;
   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic [7:0]        tid_q, tid_d;
   logic [7:0]        tuser_q, tuser_d;
   logic              tlast_q, tlast_d;
   logic              tvalid_q, tvalid_d;
   logic              ovf_q, ovf_d;
   logic              len_q, len_d;
   logic [15:0]       drop_q, drop_d;
   logic [15:0]       drop_base;
   logic [PW-1:0]     level_q, level_d;

   logic [MW-1:0]     mem [FIFO_DEPTH];
   logic [MW-1:0]     rd_word;
   logic              full;
   logic              wr_last;
   logic              wr_en;
   logic              set_ovf;
   logic              set_len;
   logic              drop_ev;
   logic              load;

   assign full    = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
   assign wr_last = wr_beat_q == BW'(FFT_BEATS - 1);
   assign rd_word = mem[rd_ptr_q[AW-1:0]];

   // Write FSM: state register
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) state_q <= ST_ACCEPT;
      else                 state_q <= state_d;
   end

   // Write FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCEPT: begin
            if (s_cp_rm_axis_tvalid) begin
               if (full)                         state_d = s_cp_rm_axis_tlast ? ST_ACCEPT : ST_DROP;
               else if (!s_cp_rm_axis_tlast && wr_last) state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (s_cp_rm_axis_tvalid && s_cp_rm_axis_tlast) state_d = ST_ACCEPT;
         end
         default: state_d = ST_ACCEPT;
      endcase
   end

   // Write FSM: pointer, beat-count and status-event actions
   always_comb begin
      wr_en     = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      cm_ptr_d  = cm_ptr_q;
      wr_beat_d = wr_beat_q;
      set_ovf   = 1'b0;
      set_len   = 1'b0;
      drop_ev   = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            if (s_cp_rm_axis_tvalid) begin
               if (full) begin
                  wr_ptr_d = cm_ptr_q;
                  set_ovf  = 1'b1;
                  drop_ev  = 1'b1;
                  if (s_cp_rm_axis_tlast) wr_beat_d = '0;
               end else if (s_cp_rm_axis_tlast && wr_last) begin
                  wr_en     = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PW'(1);
                  cm_ptr_d  = wr_ptr_q + PW'(1);
                  wr_beat_d = '0;
               end else if (s_cp_rm_axis_tlast) begin
                  wr_ptr_d  = cm_ptr_q;
                  set_len   = 1'b1;
                  drop_ev   = 1'b1;
                  wr_beat_d = '0;
               end else if (wr_last) begin
                  wr_ptr_d = cm_ptr_q;
                  set_len  = 1'b1;
                  drop_ev  = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PW'(1);
                  wr_beat_d = wr_beat_q + BW'(1);
               end
            end
         end
         ST_DROP: begin
            if (s_cp_rm_axis_tvalid && s_cp_rm_axis_tlast) wr_beat_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge s_axis_aclk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_cp_rm_axis_tid, s_cp_rm_axis_tdata};
   end

   // Read side sees commits one cycle late, fixing commit-to-valid latency at two cycles
   always_comb begin
      cm_rd_d   = cm_ptr_q;
      load      = (rd_ptr_q != cm_rd_q) && (!tvalid_q || m_fft_axis_tready);
      rd_ptr_d  = rd_ptr_q;
      rd_beat_d = rd_beat_q;
      sym_d     = sym_q;
      tdata_d   = tdata_q;
      tid_d     = tid_q;
      tuser_d   = tuser_q;
      tlast_d   = tlast_q;
      tvalid_d  = tvalid_q;
      if (load) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         tdata_d  = rd_word[DATA_W-1:0];
         tid_d    = rd_word[MW-1:DATA_W];
         tuser_d  = sym_q;
         tvalid_d = 1'b1;
         tlast_d  = rd_beat_q == BW'(FFT_BEATS - 1);
         if (rd_beat_q == BW'(FFT_BEATS - 1)) begin
            rd_beat_d = '0;
            sym_d     = (sym_q == 8'(SYMS_PER_FRAME - 1)) ? 8'd0 : sym_q + 8'd1;
         end else begin
            rd_beat_d = rd_beat_q + BW'(1);
         end
      end else if (m_fft_axis_tready) begin
         tvalid_d = 1'b0;
      end
   end

   // Sticky status: a set event on the clearing edge wins
   always_comb begin
      ovf_d     = (clr_status ? 1'b0 : ovf_q) | set_ovf;
      len_d     = (clr_status ? 1'b0 : len_q) | set_len;
      drop_base = clr_status ? 16'd0 : drop_q;
      drop_d    = (drop_ev && drop_base != 16'hFFFF) ? drop_base + 16'd1 : drop_base;
      level_d   = cm_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         wr_ptr_q  <= '0;
         cm_ptr_q  <= '0;
         cm_rd_q   <= '0;
         rd_ptr_q  <= '0;
         wr_beat_q <= '0;
         rd_beat_q <= '0;
         sym_q     <= '0;
         tdata_q   <= '0;
         tid_q     <= '0;
         tuser_q   <= '0;
         tlast_q   <= 1'b0;
         tvalid_q  <= 1'b0;
         ovf_q     <= 1'b0;
         len_q     <= 1'b0;
         drop_q    <= '0;
         level_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         cm_ptr_q  <= cm_ptr_d;
         cm_rd_q   <= cm_rd_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_beat_q <= wr_beat_d;
         rd_beat_q <= rd_beat_d;
         sym_q     <= sym_d;
         tdata_q   <= tdata_d;
         tid_q     <= tid_d;
         tuser_q   <= tuser_d;
         tlast_q   <= tlast_d;
         tvalid_q  <= tvalid_d;
         ovf_q     <= ovf_d;
         len_q     <= len_d;
         drop_q    <= drop_d;
         level_q   <= level_d;
      end
   end

   assign m_fft_axis_tdata  = tdata_q;
   assign m_fft_axis_tvalid = tvalid_q;
   assign m_fft_axis_tid    = tid_q;
   assign m_fft_axis_tuser  = tuser_q;
   assign m_fft_axis_tlast  = tlast_q;
   assign overflow          = ovf_q;
   assign len_err           = len_q;
   assign dropped_syms      = drop_q;
   assign fifo_level        = level_q;

endmodule

// File: tb/tb_fft_sym_packer.sv
// Bench for fft_sym_packer: directed scenarios with random payload/backpressure,
// checked against a symbol-level queue model of what the FFT should receive.
module tb_fft_sym_packer;

   localparam int unsigned DATA_W     = 128;
   localparam int unsigned FFT_BEATS  = 256;
   localparam int unsigned FIFO_DEPTH = 512;
   localparam int unsigned SYMS       = 14;
   localparam int unsigned PW         = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [7:0]        tid;
      logic [DATA_W-1:0] data;
      logic [7:0]        user;
      logic              last;
   } beat_t;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic [7:0]        s_tid;
   logic              s_tlast;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic [7:0]        m_tid;
   logic [7:0]        m_tuser;
   logic              m_tlast;
   logic              clr;
   logic              ovf;
   logic              lerr;
   logic [15:0]       drops;
   logic [PW-1:0]     level;

   always #5 clk = ~clk;

   fft_sym_packer dut (
      .s_axis_aclk         (clk),
      .s_axis_aresetn      (aresetn),
      .s_cp_rm_axis_tdata  (s_tdata),
      .s_cp_rm_axis_tvalid (s_tvalid),
      .s_cp_rm_axis_tid    (s_tid),
      .s_cp_rm_axis_tlast  (s_tlast),
      .m_fft_axis_tdata    (m_tdata),
      .m_fft_axis_tvalid   (m_tvalid),
      .m_fft_axis_tready   (m_tready),
      .m_fft_axis_tid      (m_tid),
      .m_fft_axis_tuser    (m_tuser),
      .m_fft_axis_tlast    (m_tlast),
      .clr_status          (clr),
      .overflow            (ovf),
      .len_err             (lerr),
      .dropped_syms        (drops),
      .fifo_level          (level)
   );

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t exp_q[$];
   int    mdl_sym = 0;
   int    mdl_drops = 0;
   bit    mdl_ovf = 1'b0;
   bit    mdl_len = 1'b0;
   bit    rnd_rdy = 1'b0;
   bit    gaps = 1'b0;
   int    cyc = 0;
   int    hs_cnt = 0;
   int    first_hs = -1;
   int    last_hs = -1;
   bit    stalled = 1'b0;
   beat_t held;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Output monitor: stall stability and in-order scoreboard
   always @(negedge clk) begin
      beat_t got;
      got = {m_tid, m_tdata, m_tuser, m_tlast};
      if (stalled) begin
         chk("stall_valid", 160'(m_tvalid), 160'(1));
         chk("stall_hold", 160'(got), 160'(held));
      end
      if (m_tvalid && m_tready) begin
         chk("beat_expected", 160'(exp_q.size() != 0), 160'(1));
         if (exp_q.size() != 0) chk("beat", 160'(got), 160'(exp_q.pop_front()));
         hs_cnt++;
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
      end
      stalled = m_tvalid && !m_tready && aresetn;
      held    = got;
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_sym(input int len, input logic [7:0] tid, input bit idx_data, input bit ok);
      beat_t sym[$];
      for (int i = 0; i < len; i++) begin
         if (gaps) while ($urandom_range(0, 2) != 0) begin s_tvalid = 1'b0; step(); end
         s_tvalid = 1'b1;
         s_tlast  = (i == len - 1);
         s_tid    = tid;
         s_tdata  = idx_data ? DATA_W'(i) : {$urandom, $urandom, $urandom, $urandom};
         sym.push_back({tid, s_tdata, 8'd0, 1'(i == FFT_BEATS - 1)});
         step();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (ok && len == FFT_BEATS) begin
         foreach (sym[k]) begin
            beat_t b;
            b = sym[k];
            b.user = 8'(mdl_sym);
            exp_q.push_back(b);
         end
         mdl_sym = (mdl_sym + 1) % SYMS;
      end else begin
         if (mdl_drops < 65535) mdl_drops++;
         if (len != FFT_BEATS) mdl_len = 1'b1;
         else                  mdl_ovf = 1'b1;
      end
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin step(); n++; end
      chk("drain_done", 160'(exp_q.size() == 0), 160'(1));
      repeat (4) step();
      chk("no_extra_beats", 160'(m_tvalid), 160'(0));
   endtask

   task automatic chk_status();
      chk("overflow", 160'(ovf), 160'(mdl_ovf));
      chk("len_err", 160'(lerr), 160'(mdl_len));
      chk("dropped_syms", 160'(drops), 160'(mdl_drops));
   endtask

   task automatic chk_zero();
      chk("rst_tvalid", 160'(m_tvalid), 160'(0));
      chk("rst_tdata", 160'(m_tdata), 160'(0));
      chk("rst_tid", 160'(m_tid), 160'(0));
      chk("rst_tuser", 160'(m_tuser), 160'(0));
      chk("rst_tlast", 160'(m_tlast), 160'(0));
      chk("rst_status", 160'({ovf, lerr, drops}), 160'(0));
      chk("rst_level", 160'(level), 160'(0));
   endtask

   task automatic do_reset();
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      step();
      step();
      exp_q.delete();
      mdl_sym   = 0;
      mdl_drops = 0;
      mdl_ovf   = 1'b0;
      mdl_len   = 1'b0;
      chk_zero();
      aresetn = 1'b1;
   endtask

   initial begin
      int hs0;
      aresetn  = 1'b0;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tid    = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      clr      = 1'b0;
      do_reset();

      // One symbol with index data; two-cycle commit-to-valid latency
      m_tready = 1'b1;
      send_sym(FFT_BEATS, 8'h05, 1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("latency_e1", 160'(m_tvalid), 160'(0));
      @(negedge clk);
      chk("latency_e2", 160'(m_tvalid), 160'(1));
      drain(2000);
      chk_status();

      // Fifteen back-to-back symbols: tuser wraps, no output gaps
      do_reset();
      first_hs = -1;
      for (int s = 0; s < 15; s++) send_sym(FFT_BEATS, 8'($urandom), 1'b0, 1'b1);
      drain(2000);
      chk("no_gaps", 160'(last_hs - first_hs), 160'(15 * FFT_BEATS - 1));
      chk_status();

      // Short and long symbols are dropped, good neighbours pass
      do_reset();
      send_sym(100, 8'h11, 1'b0, 1'b1);
      send_sym(FFT_BEATS, 8'h12, 1'b0, 1'b1);
      drain(2000);
      chk_status();
      send_sym(300, 8'h13, 1'b0, 1'b1);
      send_sym(FFT_BEATS, 8'h14, 1'b0, 1'b1);
      drain(2000);
      chk_status();

      // Clear while a short symbol ends: the set event wins
      clr = 1'b1;
      mdl_ovf = 1'b0; mdl_len = 1'b0; mdl_drops = 0;
      send_sym(10, 8'h15, 1'b0, 1'b1);
      clr = 1'b0;
      chk_status();
      clr = 1'b1; step(); clr = 1'b0;
      mdl_len = 1'b0; mdl_drops = 0;
      chk_status();

      // Overflow with FFT stalled; output register already holds one beat
      do_reset();
      m_tready = 1'b0;
      send_sym(FFT_BEATS, 8'h21, 1'b0, 1'b1);
      send_sym(FFT_BEATS, 8'h22, 1'b0, 1'b1);
      send_sym(FFT_BEATS, 8'h23, 1'b0, 1'b0);
      step();
      chk("level_plus_held", 160'(32'(level) + 32'(m_tvalid)), 160'(FIFO_DEPTH));
      chk_status();
      hs0 = hs_cnt;
      m_tready = 1'b1;
      drain(2000);
      chk("ovf_drain_beats", 160'(hs_cnt - hs0), 160'(FIFO_DEPTH));
      send_sym(FFT_BEATS, 8'h24, 1'b0, 1'b1);
      drain(2000);
      chk_status();

      // Random input gaps and random FFT backpressure
      do_reset();
      gaps = 1'b1;
      rnd_rdy = 1'b1;
      for (int s = 0; s < 4; s++) send_sym(FFT_BEATS, 8'($urandom), 1'b0, 1'b1);
      drain(6000);
      gaps = 1'b0;
      rnd_rdy = 1'b0;
      m_tready = 1'b1;
      chk_status();

      // Reset mid-symbol with a whole symbol queued
      do_reset();
      m_tready = 1'b0;
      send_sym(FFT_BEATS, 8'h31, 1'b0, 1'b1);
      for (int i = 0; i < 128; i++) begin
         s_tvalid = 1'b1;
         s_tlast  = 1'b0;
         s_tdata  = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      step();
      exp_q.delete();
      mdl_sym = 0;
      chk_zero();
      aresetn  = 1'b1;
      m_tready = 1'b1;
      send_sym(FFT_BEATS, 8'h32, 1'b0, 1'b1);
      drain(2000);
      chk_status();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
